// File: rtl/iter_alu_unit.sv
// Iterative datapath ALU: single-cycle ops, shift-add multiplier, registered result G and flags.
// All state advances on the falling edge of CLKb.
module iter_alu_unit #(
  parameter int N    = 10,
  parameter int IMMW = 6
) (
  input  logic            CLKb,
  input  logic            RSTb,
  input  logic            START,
  input  logic [3:0]      FN,
  input  logic [N-1:0]    A_IN,
  input  logic [N-1:0]    B_IN,
  input  logic [IMMW-1:0] IMM,
  input  logic            IMM_SEL,
  input  logic            Gout,
  output logic            BUSY,
  output logic            DONE,
  output logic [N-1:0]    RES,
  output logic [3:0]      FLAGS
);

  localparam int CW = $clog2(N);

  localparam logic [3:0] FN_ADD = 4'h2;
  localparam logic [3:0] FN_SUB = 4'h3;
  localparam logic [3:0] FN_INV = 4'h4;
  localparam logic [3:0] FN_FLP = 4'h5;
  localparam logic [3:0] FN_AND = 4'h6;
  localparam logic [3:0] FN_OR  = 4'h7;
  localparam logic [3:0] FN_XOR = 4'h8;
  localparam logic [3:0] FN_LSL = 4'h9;
  localparam logic [3:0] FN_LSR = 4'hA;
  localparam logic [3:0] FN_ASR = 4'hB;
  localparam logic [3:0] FN_MUL = 4'hC;
  localparam logic [3:0] FN_CMP = 4'hD;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [N-1:0]        a_p0, b_p0;
  logic [3:0]          fn_p0;
  logic [CW-1:0]       cnt;
  logic [2*N-1:0]      acc;
  logic [N-1:0]        g_p1;
  logic [3:0]          flags_p1;
  logic                vld_p1;

  logic [N-1:0]        b_sel;
  logic signed [N-1:0] a_s;
  logic [N:0]          sum, diff;
  logic [N-1:0]        res_alu;
  logic [3:0]          flg_alu;
  logic                wr_g;
  logic [2*N-1:0]      acc_nxt;
  logic [3:0]          flg_mul;
  logic                mul_last;

  function automatic logic [3:0] pack_flags(input logic [N-1:0] r, input logic c, input logic v);
    return {(r == '0), r[N-1], c, v};
  endfunction

  assign b_sel = IMM_SEL ? N'(IMM) : B_IN;
  assign a_s   = a_p0;
  assign sum   = {1'b0, a_p0} + {1'b0, b_p0};
  assign diff  = {1'b0, a_p0} - {1'b0, b_p0};

  always_comb begin
    res_alu = '0;
    flg_alu = 4'b1000;
    wr_g    = 1'b1;
    case (fn_p0)
      FN_ADD: begin
        res_alu = sum[N-1:0];
        flg_alu = pack_flags(res_alu, sum[N],
                             (a_p0[N-1] == b_p0[N-1]) && (res_alu[N-1] != a_p0[N-1]));
      end
      FN_SUB, FN_CMP: begin
        // The borrow bit of the widened difference is set exactly when A < B.
        res_alu = diff[N-1:0];
        flg_alu = pack_flags(res_alu, ~diff[N],
                             (a_p0[N-1] != b_p0[N-1]) && (res_alu[N-1] != a_p0[N-1]));
        wr_g    = (fn_p0 == FN_SUB);
      end
      FN_INV:  begin res_alu = ~a_p0 + 1'b1;     flg_alu = pack_flags(res_alu, 1'b0, 1'b0); end
      FN_FLP:  begin res_alu = ~a_p0;            flg_alu = pack_flags(res_alu, 1'b0, 1'b0); end
      FN_AND:  begin res_alu = a_p0 & b_p0;      flg_alu = pack_flags(res_alu, 1'b0, 1'b0); end
      FN_OR:   begin res_alu = a_p0 | b_p0;      flg_alu = pack_flags(res_alu, 1'b0, 1'b0); end
      FN_XOR:  begin res_alu = a_p0 ^ b_p0;      flg_alu = pack_flags(res_alu, 1'b0, 1'b0); end
      FN_LSL:  begin res_alu = a_p0 << b_p0;     flg_alu = pack_flags(res_alu, 1'b0, 1'b0); end
      FN_LSR:  begin res_alu = a_p0 >> b_p0;     flg_alu = pack_flags(res_alu, 1'b0, 1'b0); end
      FN_ASR:  begin res_alu = a_s >>> b_p0;     flg_alu = pack_flags(res_alu, 1'b0, 1'b0); end
      default: wr_g = 1'b0;
    endcase
  end

  assign mul_last = (cnt == CW'(N - 1));
  assign acc_nxt  = acc + (b_p0[cnt] ? ({{N{1'b0}}, a_p0} << cnt) : '0);
  assign flg_mul  = pack_flags(acc_nxt[N-1:0], |acc_nxt[2*N-1:N], 1'b0);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = (FN == FN_MUL) ? S_MUL : S_EXEC;
      S_EXEC:  state_nxt = S_DONE;
      S_MUL:   if (mul_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // stage p0: operand capture; stage p1: result, flags and completion pulse
  always_ff @(negedge CLKb) begin
    if (!RSTb) begin
      state    <= S_IDLE;
      a_p0     <= '0;
      b_p0     <= '0;
      fn_p0    <= '0;
      cnt      <= '0;
      acc      <= '0;
      g_p1     <= '0;
      flags_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= (state_nxt == S_DONE);
      case (state)
        S_IDLE: if (START) begin
          a_p0  <= A_IN;
          b_p0  <= b_sel;
          fn_p0 <= FN;
          cnt   <= '0;
          acc   <= '0;
        end
        S_EXEC: begin
          if (wr_g) g_p1 <= res_alu;
          flags_p1 <= flg_alu;
        end
        S_MUL: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (mul_last) begin
            g_p1     <= acc_nxt[N-1:0];
            flags_p1 <= flg_mul;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY  = (state != S_IDLE);
  assign DONE  = vld_p1;
  assign FLAGS = flags_p1;
  assign RES   = Gout ? g_p1 : '0;

endmodule

// File: tb/tb_iter_alu_unit.sv
// Directed bench for iter_alu_unit: stimulus pushes expected G/FLAGS, a monitor checks on each DONE.
module tb_iter_alu_unit;
  localparam int N    = 10;
  localparam int IMMW = 6;

  logic            CLKb, RSTb, START, IMM_SEL, Gout;
  logic [3:0]      FN;
  logic [N-1:0]    A_IN, B_IN;
  logic [IMMW-1:0] IMM;
  logic            BUSY, DONE;
  logic [N-1:0]    RES;
  logic [3:0]      FLAGS;

  typedef struct {
    logic [N-1:0] g;
    logic [3:0]   f;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_pulses = 0;

  iter_alu_unit #(.N(N), .IMMW(IMMW)) dut (
    .CLKb(CLKb), .RSTb(RSTb), .START(START), .FN(FN), .A_IN(A_IN), .B_IN(B_IN),
    .IMM(IMM), .IMM_SEL(IMM_SEL), .Gout(Gout), .BUSY(BUSY), .DONE(DONE),
    .RES(RES), .FLAGS(FLAGS)
  );

  initial CLKb = 1'b1;
  always #5 CLKb = ~CLKb;

  // DUT updates on the falling edge, so outputs are sampled on the rising edge.
  always @(posedge CLKb) begin
    if (DONE) begin
      done_pulses++;
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done: RES=%h FLAGS=%b with no pending expectation", RES, FLAGS);
      end else begin
        cur = sbq.pop_front();
        if (RES !== cur.g || FLAGS !== cur.f) begin
          miscompares++;
          $display("FAIL result: RES=%h FLAGS=%b, required RES=%h FLAGS=%b", RES, FLAGS, cur.g, cur.f);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [3:0] fn, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [IMMW-1:0] imm, input logic isel,
                       input logic [N-1:0] eg, input logic [3:0] ef, input int spam);
    int lat, exp_lat, d0;
    exp_t e;
    exp_lat = (fn == 4'hC) ? N : 1;
    e.g = eg;
    e.f = ef;
    FN = fn; A_IN = a; B_IN = b; IMM = imm; IMM_SEL = isel; START = 1'b1;
    sbq.push_back(e);
    d0 = done_pulses;
    @(negedge CLKb); #1;
    chk("busy_after_start", {31'b0, BUSY}, 1);
    START = (spam > 0);
    lat = 0;
    while (!DONE && lat < N + 4) begin
      @(negedge CLKb); #1;
      lat++;
      if (lat >= spam) START = 1'b0;
    end
    chk("done_latency", lat, exp_lat);
    chk("busy_in_done", {31'b0, BUSY}, 1);
    @(negedge CLKb); #1;
    chk("done_one_cycle", {31'b0, DONE}, 0);
    chk("idle_after_done", {31'b0, BUSY}, 0);
    chk("done_count", done_pulses - d0, 1);
    IMM_SEL = 1'b0;
  endtask

  initial begin
    int d0;
    RSTb = 1'b0; START = 1'b0; FN = '0; A_IN = '0; B_IN = '0; IMM = '0;
    IMM_SEL = 1'b0; Gout = 1'b1;
    repeat (2) @(negedge CLKb);
    #1;
    chk("rst_busy", {31'b0, BUSY}, 0);
    chk("rst_done", {31'b0, DONE}, 0);
    chk("rst_flags", {28'b0, FLAGS}, 0);
    chk("rst_res_gout1", {22'b0, RES}, 0);
    Gout = 1'b0; #1;
    chk("rst_res_gout0", {22'b0, RES}, 0);
    Gout = 1'b1;
    RSTb = 1'b1;
    @(negedge CLKb); #1;

    do_op(4'h2, 10'h3FF, 10'h001, 6'h00, 1'b0, 10'h000, 4'b1010, 0);
    Gout = 1'b0; #1;
    chk("gout0_after_add", {22'b0, RES}, 0);
    Gout = 1'b1; #1;
    do_op(4'h3, 10'h005, 10'h007, 6'h00, 1'b0, 10'h3FE, 4'b0100, 0);
    chk("res_gout1_sub", {22'b0, RES}, 32'h3FE);
    Gout = 1'b0; #1;
    chk("res_gout0_sub", {22'b0, RES}, 0);
    Gout = 1'b1; #1;
    do_op(4'hD, 10'h200, 10'h001, 6'h00, 1'b0, 10'h3FE, 4'b0011, 0);
    do_op(4'hC, 10'd31,  10'd33,  6'h00, 1'b0, 10'h3FF, 4'b0100, 0);
    do_op(4'hC, 10'd32,  10'd32,  6'h00, 1'b0, 10'h000, 4'b1010, 0);
    do_op(4'h2, 10'h001, 10'h3FF, 6'h3F, 1'b1, 10'h040, 4'b0000, 0);
    do_op(4'h9, 10'h001, 10'd12,  6'h00, 1'b0, 10'h000, 4'b1000, 0);
    do_op(4'hB, 10'h200, 10'd12,  6'h00, 1'b0, 10'h3FF, 4'b0100, 0);
    do_op(4'hB, 10'h200, 10'd0,   6'h00, 1'b0, 10'h200, 4'b0100, 0);
    do_op(4'h2, 10'h1FF, 10'h001, 6'h00, 1'b0, 10'h200, 4'b0101, 0);
    do_op(4'h4, 10'h001, 10'h000, 6'h00, 1'b0, 10'h3FF, 4'b0100, 0);
    do_op(4'h5, 10'h0F0, 10'h000, 6'h00, 1'b0, 10'h30F, 4'b0100, 0);
    do_op(4'h6, 10'h3F0, 10'h0FF, 6'h00, 1'b0, 10'h0F0, 4'b0000, 0);
    do_op(4'h7, 10'h300, 10'h00F, 6'h00, 1'b0, 10'h30F, 4'b0100, 0);
    do_op(4'h8, 10'h3FF, 10'h3FF, 6'h00, 1'b0, 10'h000, 4'b1000, 0);
    do_op(4'hA, 10'h200, 10'd3,   6'h00, 1'b0, 10'h040, 4'b0000, 0);
    do_op(4'hA, 10'h3FF, 10'd10,  6'h00, 1'b0, 10'h000, 4'b1000, 0);
    do_op(4'hC, 10'd3,   10'd5,   6'h00, 1'b0, 10'h00F, 4'b0000, 5);
    do_op(4'hF, 10'h123, 10'h045, 6'h00, 1'b0, 10'h00F, 4'b1000, 0);
    do_op(4'h0, 10'h000, 10'h000, 6'h00, 1'b0, 10'h00F, 4'b1000, 0);
    do_op(4'hD, 10'h005, 10'h005, 6'h00, 1'b0, 10'h00F, 4'b1010, 0);

    // Abort a multiply with reset asserted for edge 4.
    FN = 4'hC; A_IN = 10'd7; B_IN = 10'd9; START = 1'b1;
    @(negedge CLKb); #1;
    START = 1'b0;
    repeat (3) @(negedge CLKb);
    #1;
    RSTb = 1'b0;
    d0 = done_pulses;
    @(negedge CLKb); #1;
    chk("abort_busy", {31'b0, BUSY}, 0);
    chk("abort_done", {31'b0, DONE}, 0);
    chk("abort_flags", {28'b0, FLAGS}, 0);
    chk("abort_res", {22'b0, RES}, 0);
    RSTb = 1'b1;
    repeat (N + 3) @(negedge CLKb);
    #1;
    chk("abort_no_done", done_pulses - d0, 0);
    chk("abort_idle", {31'b0, BUSY}, 0);
    do_op(4'h2, 10'd2, 10'd3, 6'h00, 1'b0, 10'h005, 4'b0000, 0);

    repeat (2) @(negedge CLKb);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
